// File: rtl/cache_miss_fill_ctrl.sv
// cache_miss_fill_ctrl
//   Shared miss controller sitting between the I-cache, the D-cache and the single
//   pipelined memory4c read port. A pending D-cache miss wins over an I-cache miss.
//   The controller fetches the whole block, streams each returned word into the
//   selected cache's data array and writes that cache's tag with the last word.
//
// Ports
//   clk, rst                       clock (rising edge), asynchronous active-high reset
//   d_cache_miss_detected/address  D-cache miss request (level) and byte address
//   i_cache_miss_detected/address  I-cache miss request (level) and byte address
//   memory_data_valid              memory4c read data valid this cycle
//   memory_address, memory_rd_en   read request presented to memory4c
//   cache_fill_address             cache write address for the word returning now
//   d_cache_fsm_data_wen/tag_wen   D-cache data array / tag write enables
//   i_cache_fsm_data_wen/tag_wen   I-cache data array / tag write enables
//   fill_busy                      high while a fill is in flight (FILL and DONE)
module cache_miss_fill_ctrl #(
    parameter int unsigned AWIDTH      = 16,
    parameter int unsigned BLOCK_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_cache_miss_detected,
    input  logic [AWIDTH-1:0] d_cache_miss_address,
    input  logic              i_cache_miss_detected,
    input  logic [AWIDTH-1:0] i_cache_miss_address,
    input  logic              memory_data_valid,
    output logic [AWIDTH-1:0] memory_address,
    output logic              memory_rd_en,
    output logic [AWIDTH-1:0] cache_fill_address,
    output logic              d_cache_fsm_data_wen,
    output logic              d_cache_fsm_tag_wen,
    output logic              i_cache_fsm_data_wen,
    output logic              i_cache_fsm_tag_wen,
    output logic              fill_busy
);

    // Byte offset bits within a block (16-bit words, so 2 bytes per word).
    localparam int unsigned Offs = $clog2(BLOCK_WORDS * 2);

    localparam logic [3:0] NumWords = 4'(BLOCK_WORDS);
    localparam logic [3:0] LastWord = 4'(BLOCK_WORDS - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StFill = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        iss_cnt_q, iss_cnt_d;
    logic [3:0]        rcv_cnt_q, rcv_cnt_d;
    logic              sel_dcache_q, sel_dcache_d;
    logic [AWIDTH-1:0] base_q, base_d;

    // Low address bits select a word inside the block and are dropped on purpose.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{d_cache_miss_address[Offs-1:0],
                                  i_cache_miss_address[Offs-1:0]};

    always_comb begin
        state_d              = state_q;
        iss_cnt_d            = iss_cnt_q;
        rcv_cnt_d            = rcv_cnt_q;
        sel_dcache_d         = sel_dcache_q;
        base_d               = base_q;
        memory_rd_en         = 1'b0;
        memory_address       = base_q;
        cache_fill_address   = base_q;
        d_cache_fsm_data_wen = 1'b0;
        d_cache_fsm_tag_wen  = 1'b0;
        i_cache_fsm_data_wen = 1'b0;
        i_cache_fsm_tag_wen  = 1'b0;
        fill_busy            = 1'b0;

        case (state_q)
            StIdle: begin
                // D-cache checked first so it wins a tie.
                if (d_cache_miss_detected) begin
                    base_d       = {d_cache_miss_address[AWIDTH-1:Offs], {Offs{1'b0}}};
                    sel_dcache_d = 1'b1;
                    iss_cnt_d    = '0;
                    rcv_cnt_d    = '0;
                    state_d      = StFill;
                end else if (i_cache_miss_detected) begin
                    base_d       = {i_cache_miss_address[AWIDTH-1:Offs], {Offs{1'b0}}};
                    sel_dcache_d = 1'b0;
                    iss_cnt_d    = '0;
                    rcv_cnt_d    = '0;
                    state_d      = StFill;
                end
            end

            StFill: begin
                fill_busy = 1'b1;
                // Issue and receive overlap because memory4c is pipelined.
                if (iss_cnt_q < NumWords) begin
                    memory_rd_en   = 1'b1;
                    memory_address = base_q + AWIDTH'({iss_cnt_q, 1'b0});
                    iss_cnt_d      = iss_cnt_q + 4'd1;
                end
                // Completion counts returned words, so any memory latency works.
                if (memory_data_valid) begin
                    cache_fill_address   = base_q + AWIDTH'({rcv_cnt_q, 1'b0});
                    d_cache_fsm_data_wen = sel_dcache_q;
                    i_cache_fsm_data_wen = ~sel_dcache_q;
                    rcv_cnt_d            = rcv_cnt_q + 4'd1;
                    if (rcv_cnt_q == LastWord) begin
                        d_cache_fsm_tag_wen = sel_dcache_q;
                        i_cache_fsm_tag_wen = ~sel_dcache_q;
                        state_d             = StDone;
                    end
                end
            end

            StDone: begin
                // One quiet cycle so the freshly written tag settles before re-arbitration.
                fill_busy = 1'b1;
                state_d   = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            iss_cnt_q    <= '0;
            rcv_cnt_q    <= '0;
            sel_dcache_q <= 1'b0;
            base_q       <= '0;
        end else begin
            state_q      <= state_d;
            iss_cnt_q    <= iss_cnt_d;
            rcv_cnt_q    <= rcv_cnt_d;
            sel_dcache_q <= sel_dcache_d;
            base_q       <= base_d;
        end
    end

endmodule

// File: tb/tb_cache_miss_fill_ctrl.sv
// Self-checking bench for cache_miss_fill_ctrl.
module tb_cache_miss_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_cache_miss_detected;
    logic [15:0] d_cache_miss_address;
    logic        i_cache_miss_detected;
    logic [15:0] i_cache_miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_address;
    logic        memory_rd_en;
    logic [15:0] cache_fill_address;
    logic        d_cache_fsm_data_wen;
    logic        d_cache_fsm_tag_wen;
    logic        i_cache_fsm_data_wen;
    logic        i_cache_fsm_tag_wen;
    logic        fill_busy;

    logic model_valid = 1'b0;
    logic extra_valid = 1'b0;
    logic gap_mode    = 1'b0;
    assign memory_data_valid = model_valid | extra_valid;

    int n_checks = 0;
    int n_pass   = 0;
    int n_tags   = 0;
    int n_dwen   = 0;

    logic [16:0] wq[$];  // {sel_dcache, fill address} expected per data write
    logic [15:0] iq[$];  // expected memory read addresses

    always #5 clk = ~clk;

    cache_miss_fill_ctrl #(.AWIDTH(16), .BLOCK_WORDS(8)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .d_cache_miss_detected (d_cache_miss_detected),
        .d_cache_miss_address  (d_cache_miss_address),
        .i_cache_miss_detected (i_cache_miss_detected),
        .i_cache_miss_address  (i_cache_miss_address),
        .memory_data_valid     (memory_data_valid),
        .memory_address        (memory_address),
        .memory_rd_en          (memory_rd_en),
        .cache_fill_address    (cache_fill_address),
        .d_cache_fsm_data_wen  (d_cache_fsm_data_wen),
        .d_cache_fsm_tag_wen   (d_cache_fsm_tag_wen),
        .i_cache_fsm_data_wen  (i_cache_fsm_data_wen),
        .i_cache_fsm_tag_wen   (i_cache_fsm_tag_wen),
        .fill_busy             (fill_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push_fill(input logic sel, input logic [15:0] addr);
        logic [15:0] base;
        base = addr & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            wq.push_back({sel, base + 16'(2 * k)});
            iq.push_back(base + 16'(2 * k));
        end
    endtask

    // Waits (bounded) for all expected writes to land and the controller to go idle.
    task automatic wait_fill_done(input string tag);
        int n;
        n = 0;
        sample();
        while ((wq.size() != 0 || fill_busy) && n < 300) begin
            next();
            sample();
            n++;
        end
        check(tag, 32'(n < 300), 1);
        next();
    endtask

    // Memory model: valid 4 cycles after rd_en, or gapped (1,0,0,...) in gap mode.
    initial begin
        logic [3:0] sh;
        int outstanding;
        int gcnt;
        sh = '0;
        outstanding = 0;
        gcnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sh = '0;
                outstanding = 0;
                gcnt = 0;
            end else begin
                sh = {sh[2:0], memory_rd_en};
                if (memory_rd_en) outstanding++;
            end
            @(posedge clk);
            #1;
            if (rst) begin
                model_valid = 1'b0;
            end else if (gap_mode) begin
                if (outstanding > 0) begin
                    model_valid = (gcnt % 3 == 0);
                    if (model_valid) outstanding--;
                    gcnt++;
                end else begin
                    model_valid = 1'b0;
                end
            end else begin
                model_valid = sh[3];
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        logic [16:0] e;
        logic [15:0] ea;
        logic        last_sel;
        int          writes_in_fill;
        last_sel = 1'b0;
        writes_in_fill = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                writes_in_fill = 0;
            end else begin
                if (memory_rd_en) begin
                    if (iq.size() == 0) check("rd_unexpected", 1, 0);
                    else begin
                        ea = iq.pop_front();
                        check("rd_addr", 32'(memory_address), 32'(ea));
                    end
                end
                if (d_cache_fsm_data_wen | i_cache_fsm_data_wen) begin
                    n_dwen++;
                    if (wq.size() == 0) begin
                        check("wen_unexpected", {d_cache_fsm_data_wen, i_cache_fsm_data_wen}, 0);
                    end else begin
                        e = wq.pop_front();
                        last_sel = e[16];
                        check("fill_addr", 32'(cache_fill_address), 32'(e[15:0]));
                        check("wen_sel", {d_cache_fsm_data_wen, i_cache_fsm_data_wen},
                              {e[16], ~e[16]});
                        writes_in_fill++;
                    end
                end
                if (d_cache_fsm_tag_wen | i_cache_fsm_tag_wen) begin
                    n_tags++;
                    check("tag_sel", {d_cache_fsm_tag_wen, i_cache_fsm_tag_wen},
                          {last_sel, ~last_sel});
                    check("tag_on_8th", 32'(writes_in_fill), 8);
                    check("tag_with_data", 32'(d_cache_fsm_data_wen | i_cache_fsm_data_wen), 1);
                    writes_in_fill = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int tags0;
        int dwen0;
        logic found;
        logic [37:0] outs;

        rst = 1'b1;
        d_cache_miss_detected = 1'b1;
        d_cache_miss_address  = 16'h1236;
        i_cache_miss_detected = 1'b1;
        i_cache_miss_address  = 16'h2008;
        next();
        next();
        sample();
        outs = {memory_address, memory_rd_en, cache_fill_address, d_cache_fsm_data_wen,
                d_cache_fsm_tag_wen, i_cache_fsm_data_wen, i_cache_fsm_tag_wen, fill_busy};
        check("reset_outputs", 32'(outs[37:6]), 0);
        check("reset_outputs_lo", 32'(outs[5:0]), 0);
        d_cache_miss_detected = 1'b0;
        i_cache_miss_detected = 1'b0;
        next();
        rst = 1'b0;
        next();

        // 1: D miss at 0x1236, fixed 4-cycle memory latency.
        d_cache_miss_detected = 1'b1;
        d_cache_miss_address  = 16'h1236;
        push_fill(1'b1, 16'h1236);
        for (int c = 0; c <= 14; c++) begin
            sample();
            check($sformatf("t1_rd_en_c%0d", c), 32'(memory_rd_en), 32'(c >= 1 && c <= 8));
            check($sformatf("t1_busy_c%0d", c), 32'(fill_busy), 32'(c >= 1 && c <= 13));
            check($sformatf("t1_dwen_c%0d", c), 32'(d_cache_fsm_data_wen),
                  32'(c >= 5 && c <= 12));
            check($sformatf("t1_dtag_c%0d", c), 32'(d_cache_fsm_tag_wen), 32'(c == 12));
            check($sformatf("t1_iquiet_c%0d", c),
                  32'({i_cache_fsm_data_wen, i_cache_fsm_tag_wen}), 0);
            next();
            if (c == 0) d_cache_miss_detected = 1'b0;
        end

        // 2: D and I miss together; D wins, I follows after DONE + one IDLE cycle.
        d_cache_miss_detected = 1'b1;
        d_cache_miss_address  = 16'h0040;
        i_cache_miss_detected = 1'b1;
        i_cache_miss_address  = 16'h2008;
        push_fill(1'b1, 16'h0040);
        push_fill(1'b0, 16'h2008);
        next();
        d_cache_miss_detected = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            sample();
            check("t2_i_quiet", 32'({i_cache_fsm_data_wen, i_cache_fsm_tag_wen}), 0);
            if (d_cache_fsm_tag_wen) found = 1'b1;
            else next();
        end
        check("t2_d_tag_seen", 32'(found), 1);
        next();
        sample();
        check("t2_done_busy", 32'(fill_busy), 1);
        check("t2_done_rd", 32'(memory_rd_en), 0);
        next();
        sample();
        check("t2_idle_busy", 32'(fill_busy), 0);
        next();
        sample();
        check("t2_i_start_rd", 32'(memory_rd_en), 1);
        check("t2_i_start_addr", 32'(memory_address), 32'h2000);
        next();
        i_cache_miss_detected = 1'b0;
        wait_fill_done("t2_done");

        // 3: gapped valids; exactly 8 writes and the tag on the 8th.
        gap_mode = 1'b1;
        dwen0 = n_dwen;
        tags0 = n_tags;
        d_cache_miss_detected = 1'b1;
        d_cache_miss_address  = 16'h4A5C;
        push_fill(1'b1, 16'h4A5C);
        next();
        d_cache_miss_detected = 1'b0;
        wait_fill_done("t3_done");
        gap_mode = 1'b0;
        check("t3_wen_count", 32'(n_dwen - dwen0), 8);
        check("t3_tag_count", 32'(n_tags - tags0), 1);

        // 4: reset in cycle 6 of an I fill, then a fresh I miss restarts at word 0.
        tags0 = n_tags;
        i_cache_miss_detected = 1'b1;
        i_cache_miss_address  = 16'h3004;
        push_fill(1'b0, 16'h3004);
        next();
        i_cache_miss_detected = 1'b0;
        for (int c = 1; c < 6; c++) next();
        rst = 1'b1;
        wq.delete();
        iq.delete();
        #1;
        check("t4_rst_rd", 32'(memory_rd_en), 0);
        check("t4_rst_busy", 32'(fill_busy), 0);
        check("t4_rst_wen", 32'({d_cache_fsm_data_wen, d_cache_fsm_tag_wen,
                                  i_cache_fsm_data_wen, i_cache_fsm_tag_wen}), 0);
        check("t4_rst_addr", 32'({memory_address, cache_fill_address}), 0);
        next();
        next();
        rst = 1'b0;
        next();
        next();
        check("t4_no_tag", 32'(n_tags - tags0), 0);
        i_cache_miss_detected = 1'b1;
        i_cache_miss_address  = 16'h3010;
        push_fill(1'b0, 16'h3010);
        next();
        i_cache_miss_detected = 1'b0;
        sample();
        check("t4_restart_rd", 32'(memory_rd_en), 1);
        check("t4_restart_addr", 32'(memory_address), 32'h3010);
        wait_fill_done("t4_done");
        check("t4_tag_count", 32'(n_tags - tags0), 1);

        // 5: stray valid in IDLE is ignored; a dropped miss still completes.
        extra_valid = 1'b1;
        sample();
        check("t5_stray_wen", 32'({d_cache_fsm_data_wen, d_cache_fsm_tag_wen,
                                   i_cache_fsm_data_wen, i_cache_fsm_tag_wen}), 0);
        check("t5_stray_busy", 32'(fill_busy), 0);
        next();
        extra_valid = 1'b0;
        sample();
        check("t5_still_idle", 32'({fill_busy, memory_rd_en}), 0);
        next();
        tags0 = n_tags;
        d_cache_miss_detected = 1'b1;
        d_cache_miss_address  = 16'h0102;
        push_fill(1'b1, 16'h0102);
        next();
        next();
        next();
        d_cache_miss_detected = 1'b0;
        wait_fill_done("t5_done");
        check("t5_tag_count", 32'(n_tags - tags0), 1);
        check("t5_queues_empty", 32'(wq.size() + iq.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
